// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler: one base prescaler feeding NUM_CH per-channel
// period counters, reconfigured through a single-entry write port applied on base ticks.
module tick_channel #(
    parameter int PER_W = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             base_tick_i,
    input  logic             wr_i,
    input  logic [PER_W-1:0] wr_period_i,
    input  logic             wr_en_i,
    output logic             tick_o,
    output logic             active_o
);
    logic [PER_W-1:0] period_q, cnt_q;
    logic             en_q, tick_q;

    assign active_o = en_q && (period_q != '0);
    assign tick_o   = tick_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            period_q <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (base_tick_i) begin
                // A write on this edge replaces the tick decision for this channel
                if (wr_i) begin
                    period_q <= wr_period_i;
                    en_q     <= wr_en_i;
                    cnt_q    <= '0;
                end else if (active_o) begin
                    if (cnt_q == period_q - 1'b1) begin
                        cnt_q  <= '0;
                        tick_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end
    end
endmodule

module tick_scheduler #(
    parameter int BASE_DIV = 1250000,
    parameter int NUM_CH   = 4,
    parameter int PER_W    = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic              cfg_enable,
    output logic              base_tick,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] ch_active,
    output logic              cfg_pending
);
    localparam int PRE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [PER_W-1:0] period;
        logic             en;
    } cfg_t;

    typedef enum logic {IDLE, PENDING} state_t;

    logic [PRE_W-1:0]  pre_cnt_q;
    state_t            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic              apply;
    logic [NUM_CH-1:0] wr_vec;

    assign base_tick = (pre_cnt_q == PRE_W'(BASE_DIV - 1));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            pre_cnt_q <= '0;
            state_q   <= IDLE;
            cfg_q     <= '0;
        end else begin
            pre_cnt_q <= base_tick ? '0 : pre_cnt_q + 1'b1;
            state_q   <= state_d;
            cfg_q     <= cfg_d;
        end
    end

    // A handshake in IDLE never applies on the same edge, so a write
    // accepted during a base_tick cycle waits for the next one.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && !reset) begin
                    state_d = PENDING;
                    cfg_d   = '{ch: cfg_ch, period: cfg_period, en: cfg_enable};
                end
            end
            PENDING: begin
                if (base_tick) begin
                    apply   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready   = reset || (state_q == IDLE);
    assign cfg_pending = !reset && (state_q == PENDING);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_vec[g] = apply && (cfg_q.ch == CH_W'(g));
        tick_channel #(.PER_W(PER_W)) u_ch (
            .clk_in      (clk_in),
            .reset       (reset),
            .base_tick_i (base_tick),
            .wr_i        (wr_vec[g]),
            .wr_period_i (cfg_q.period),
            .wr_en_i     (cfg_q.en),
            .tick_o      (tick_out[g]),
            .active_o    (ch_active[g])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (BASE_DIV=4, NUM_CH=4): per-cycle arithmetic model plus literal pins.
module tb_tick_scheduler;
    localparam int BD = 4;
    localparam int NC = 4;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch = '0;
    logic [7:0]    cfg_period = '0;
    logic          cfg_enable = 1'b0;
    logic          base_tick;
    logic [NC-1:0] tick_out, ch_active;
    logic          cfg_pending;

    tick_scheduler #(.BASE_DIV(BD), .NUM_CH(NC), .PER_W(8)) dut (
        .clk_in(clk_in), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_enable(cfg_enable),
        .base_tick(base_tick), .tick_out(tick_out), .ch_active(ch_active),
        .cfg_pending(cfg_pending)
    );

    always #5 clk_in = ~clk_in;

    int vecs = 0, errs = 0;
    int n = 0, ncyc = 0;

    // model state
    bit pend;
    int p_ch, p_per, p_en, p_c;
    int m_per[NC], m_en[NC], m_org[NC];

    // per-phase logs
    int tk0_q[$], rdylo_q[$], acc_q[$], bt_q[$];
    int act_cnt;
    int first_act[NC];

    task automatic chk(string nm, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, n, act, exp);
        end
    endtask

    task automatic chk_seq(string nm, input int q[$], input int e[$], input bit exact);
        if (exact) chk({nm, "_len"}, q.size(), e.size());
        foreach (e[i]) chk(nm, (i < q.size()) ? q[i] : -1, e[i]);
    endtask

    // Compare process: outputs are stable at the falling edge
    initial begin
        int e_act, e_tk, d;
        bit acc;
        forever begin
            @(negedge clk_in);
            if (reset) begin
                chk("rst_ready", int'(cfg_ready), 1);
                pend = 0;
                for (int i = 0; i < NC; i++) begin
                    m_per[i] = 0; m_en[i] = 0; m_org[i] = 0;
                end
                n = 0;
            end else begin
                e_act = 0; e_tk = 0;
                for (int i = 0; i < NC; i++) begin
                    if (m_en[i] != 0 && m_per[i] != 0) begin
                        e_act |= (1 << i);
                        d = n - m_org[i] - 1;
                        if (d > 0 && d % (m_per[i] * BD) == 0) e_tk |= (1 << i);
                    end
                end
                chk("base_tick", int'(base_tick), (n % BD == BD - 1) ? 1 : 0);
                chk("tick_out", int'(tick_out), e_tk);
                chk("ch_active", int'(ch_active), e_act);
                chk("cfg_ready", int'(cfg_ready), pend ? 0 : 1);
                chk("cfg_pending", int'(cfg_pending), pend ? 1 : 0);
                if (tick_out[0]) tk0_q.push_back(n);
                if (!cfg_ready) rdylo_q.push_back(n);
                if (cfg_valid && cfg_ready) acc_q.push_back(n);
                if (base_tick) bt_q.push_back(n);
                if (ch_active != '0) act_cnt++;
                for (int i = 0; i < NC; i++)
                    if (ch_active[i] && first_act[i] < 0) first_act[i] = n;
                acc = cfg_valid && !pend;
                if (pend && n == p_c) begin
                    if (p_ch < NC) begin
                        m_per[p_ch] = p_per; m_en[p_ch] = p_en; m_org[p_ch] = n;
                    end
                    pend = 0;
                end
                if (acc) begin
                    pend = 1;
                    p_ch = int'(cfg_ch); p_per = int'(cfg_period); p_en = int'(cfg_enable);
                    p_c = n + 1;
                    while (p_c % BD != BD - 1) p_c++;
                end
                n++;
            end
        end
    end

    task automatic go_to(int k);
        while (ncyc < k) begin
            @(posedge clk_in); #1;
            ncyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_valid = 1'b0;
        @(posedge clk_in); #1;
        reset = 1'b0; ncyc = 0;
        tk0_q.delete(); rdylo_q.delete(); acc_q.delete(); bt_q.delete();
        act_cnt = 0;
        for (int i = 0; i < NC; i++) first_act[i] = -1;
    endtask

    task automatic wr(int k, int ch, int per, int en);
        go_to(k);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(per); cfg_enable = en[0];
        go_to(k + 1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int e[$];
        @(posedge clk_in); #1;

        // basic write, period 1, period 0
        do_reset();
        wr(0, 0, 3, 1);
        wr(4, 1, 1, 1);
        wr(8, 2, 0, 1);
        go_to(45);
        e = '{16, 28, 40};  chk_seq("p1_tick0", tk0_q, e, 1'b1);
        e = '{1, 2, 3};     chk_seq("p1_rdylo", rdylo_q, e, 1'b0);
        e = '{3, 7, 11};    chk_seq("p1_btick", bt_q, e, 1'b0);
        chk("p1_act0_first", first_act[0], 4);
        chk("p1_act2_first", first_act[2], -1);

        // write on a base_tick cycle, second write held
        do_reset();
        go_to(3);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd1; cfg_enable = 1'b1;
        go_to(4);
        cfg_ch = 2'd2; cfg_period = 8'd2;
        go_to(9);
        cfg_valid = 1'b0;
        go_to(30);
        e = '{3, 8};        chk_seq("p2_accept", acc_q, e, 1'b1);
        chk("p2_act3_first", first_act[3], 8);
        chk("p2_act2_first", first_act[2], 12);

        // reconfigure a running channel
        do_reset();
        wr(0, 0, 3, 1);
        wr(4, 1, 1, 1);
        wr(20, 0, 2, 1);
        go_to(45);
        e = '{16, 32, 40};  chk_seq("p3_tick0", tk0_q, e, 1'b1);

        // reset while a write is pending
        do_reset();
        wr(0, 0, 1, 1);
        go_to(2);
        do_reset();
        go_to(12);
        e = '{3, 7, 11};    chk_seq("p4_btick", bt_q, e, 1'b0);
        chk("p4_act_cycles", act_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
